// File: rtl/dropout_sequencer.sv
// Dropout sequencer: streams one vector through a one-deep output register,
// zeroing elements whose LFSR draw falls below the latched drop threshold.
module dropout_sequencer #(
    parameter int          VEC_LEN   = 16,
    parameter int          DATA_W    = 8,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           train_en,
    input  logic [7:0]                     drop_thresh,
    input  logic [DATA_W-1:0]              in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [DATA_W-1:0]              out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           out_last,
    output logic                           busy,
    output logic                           done,
    output logic [$clog2(VEC_LEN+1)-1:0]   drop_count
);

    localparam int CNT_W = $clog2(VEC_LEN + 1);
    localparam logic [CNT_W-1:0] LEN_C  = CNT_W'(VEC_LEN);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(VEC_LEN - 1);
    localparam logic [15:0] SEED_C = (LFSR_SEED == 16'h0) ? 16'h0001 : LFSR_SEED;
    localparam logic [15:0] POLY_C = 16'hB400;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                train_q, train_d;
    logic [7:0]          thresh_q, thresh_d;
    logic [15:0]         lfsr_q, lfsr_d;
    logic [DATA_W-1:0]   odata_q, odata_d;
    logic                ovalid_q, ovalid_d;
    logic                olast_q, olast_d;

    logic rdy;
    logic accept;
    logic handoff;
    logic drop;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        train_d  = train_q;
        thresh_d = thresh_q;
        lfsr_d   = lfsr_q;
        odata_d  = odata_q;
        ovalid_d = ovalid_q;
        olast_d  = olast_q;
        rdy      = 1'b0;
        accept   = 1'b0;
        handoff  = ovalid_q && out_ready;
        drop     = train_q && (lfsr_q[7:0] < thresh_q);

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    train_d  = train_en;
                    thresh_d = drop_thresh;
                    idx_d    = '0;
                    cnt_d    = '0;
                    olast_d  = 1'b0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                // Input closes once the final element has been taken.
                rdy    = (idx_q != LEN_C) && (!ovalid_q || out_ready);
                accept = rdy && in_valid;
                if (handoff) begin
                    ovalid_d = 1'b0;
                end
                if (accept) begin
                    odata_d  = drop ? '0 : in_data;
                    ovalid_d = 1'b1;
                    olast_d  = (idx_q == LAST_C);
                    idx_d    = idx_q + 1'b1;
                    lfsr_d   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? POLY_C : 16'h0);
                    if (drop) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                if (handoff && olast_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            train_q  <= 1'b0;
            thresh_q <= '0;
            lfsr_q   <= SEED_C;
            odata_q  <= '0;
            ovalid_q <= 1'b0;
            olast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            train_q  <= train_d;
            thresh_q <= thresh_d;
            lfsr_q   <= lfsr_d;
            odata_q  <= odata_d;
            ovalid_q <= ovalid_d;
            olast_q  <= olast_d;
        end
    end

    assign in_ready   = rdy;
    assign out_data   = odata_q;
    assign out_valid  = ovalid_q;
    assign out_last   = olast_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign drop_count = cnt_q;

endmodule

// File: tb/tb_dropout_sequencer.sv
// Randomized bench for dropout_sequencer against a queue-based
// scoreboard and a behavioural LFSR mask model.
module tb_dropout_sequencer;

    localparam int VL = 16;
    localparam int DW = 8;
    localparam int CW = $clog2(VL + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          train_en = 1'b0;
    logic [7:0]    drop_thresh = 8'h0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_last;
    logic          busy;
    logic          done;
    logic [CW-1:0] drop_count;

    dropout_sequencer #(
        .VEC_LEN  (VL),
        .DATA_W   (DW),
        .LFSR_SEED(16'hACE1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .train_en   (train_en),
        .drop_thresh(drop_thresh),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } exp_t;

    exp_t        q[$];
    logic [15:0] m_lfsr;
    int          tot_drops;
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        logic [15:0] n;
        n = s >> 1;
        if (s[0]) n = n ^ 16'hB400;
        return n;
    endfunction

    task automatic chk_reset_vals();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rdy", in_ready, 0);
        chk("rst_ov", out_valid, 0);
        chk("rst_ol", out_last, 0);
        chk("rst_od", out_data, 0);
        chk("rst_cnt", drop_count, 0);
    endtask

    task automatic run_vec(input bit tr, input logic [7:0] th, input int vp,
                           input int rp, input int dmode, input int rst_at,
                           input bit mid_start);
        logic [DW-1:0] vd[VL];
        int            n_acc;
        int            m_drops;
        int            exp_done;
        bit            seen;
        bit            stall;
        bit            drop;
        logic [DW-1:0] pd;
        logic          pl;
        exp_t          e;
        for (int i = 0; i < VL; i++) begin
            if (dmode == 0) vd[i] = DW'(i + 1);
            else if (dmode == 1) vd[i] = '1;
            else vd[i] = DW'($urandom);
        end
        n_acc = 0; m_drops = 0; exp_done = -1;
        seen = 0; stall = 0; pd = '0; pl = 0;
        q.delete();
        @(negedge clk);
        start = 1; train_en = tr; drop_thresh = th;
        in_valid = 0; out_ready = 1;
        for (int c = 1; c <= 400 && !seen; c++) begin
            @(negedge clk);
            start = mid_start && (c == 4);
            drop_thresh = start ? 8'd255 : 8'($urandom);
            train_en = start ? 1'b1 : 1'($urandom);
            if (rst_at >= 0 && n_acc == rst_at) begin
                rst = 1; in_valid = 0;
                @(negedge clk);
                rst = 0;
                #1;
                chk_reset_vals();
                m_lfsr = 16'hACE1;
                q.delete();
                return;
            end
            in_valid = (n_acc < VL) && ($urandom_range(99) < vp);
            in_data = vd[(n_acc < VL) ? n_acc : 0];
            out_ready = $urandom_range(99) < rp;
            #1;
            if (c == 1) chk("busy_on", busy, 1);
            if (stall) begin
                chk("stall_ov", out_valid, 1);
                chk("stall_od", out_data, pd);
                chk("stall_ol", out_last, pl);
            end
            chk("ovalid", out_valid, q.size() != 0);
            if (out_valid && !out_ready) chk("rdy_stall", in_ready, 0);
            if (n_acc == VL) chk("rdy_end", in_ready, 0);
            if (done) begin
                seen = 1;
                chk("done_cyc", c, exp_done);
                chk("drops", drop_count, m_drops);
                if (vp == 100 && rp == 100) chk("latency", c, VL + 2);
            end
            stall = out_valid && !out_ready;
            pd = out_data;
            pl = out_last;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("extra_out", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("data", out_data, e.d);
                    chk("last", out_last, e.l);
                    if (e.l) exp_done = c + 1;
                end
            end
            if (in_valid && in_ready) begin
                drop = tr && (m_lfsr[7:0] < th);
                e.d = drop ? '0 : vd[n_acc];
                e.l = (n_acc == VL - 1);
                q.push_back(e);
                m_lfsr = lfsr_next(m_lfsr);
                if (drop) m_drops++;
                n_acc++;
            end
        end
        if (!seen) chk("timeout", 0, 1);
        @(negedge clk);
        start = 0; in_valid = 0;
        #1;
        chk("done_once", done, 0);
        chk("busy_off", busy, 0);
        chk("cnt_hold", drop_count, m_drops);
        tot_drops += m_drops;
    endtask

    initial begin
        m_lfsr = 16'hACE1;
        tot_drops = 0;
        rst = 1;
        repeat (2) @(negedge clk);
        #1;
        chk_reset_vals();
        rst = 0;
        run_vec(1, 8'd0, 100, 100, 0, -1, 0);
        run_vec(0, 8'd255, 100, 100, 1, -1, 0);
        run_vec(1, 8'd128, 100, 100, 2, -1, 0);
        tot_drops = 0;
        repeat (64) run_vec(1, 8'd128, 100, 100, 2, -1, 0);
        chk("drop_pct", (tot_drops >= 410) && (tot_drops <= 614), 1);
        repeat (8) run_vec(1, 8'd128, 60, 50, 2, -1, 0);
        run_vec(1, 8'd128, 80, 70, 2, 5, 0);
        run_vec(1, 8'd128, 100, 100, 2, -1, 0);
        run_vec(1, 8'd32, 100, 100, 2, -1, 1);
        run_vec(1, 8'd32, 70, 60, 2, -1, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dropout_sequencer.md
# dropout_sequencer

Sequential controller for the second dropout stage in the neural-network datapath. It streams the OUT_SIZE_2 activations of one vector element-by-element through a valid/ready handshake. Each element is either zeroed or passed through, based on a deterministic LFSR draw compared against a programmable drop threshold. The block sits between the layer-2 output and the next dense layer, and replaces simulation-only randomness with synthesizable, reproducible mask generation. In inference mode (train_en low) it is a registered pass-through with the same handshake and framing.

## Interface
- VEC_LEN, default OUT_SIZE_2 (from nn_parameters): elements per vector, ≥ 2
- DATA_W, default 8: element width
- LFSR_SEED, default 16'hACE1: LFSR reset value; a seed of 0 is replaced by 16'h0001
- clk  in  1  clock; one clock domain
- rst  in  1  synchronous, active-high reset
- start  in  1  begin one vector; sampled only in IDLE
- train_en  in  1  dropout enabled; latched on accepted start
- drop_thresh  in  8  drop probability = drop_thresh/256; latched on accepted start
- in_data  in  DATA_W  input element
- in_valid  in  1  input element valid
- in_ready  out  1  block accepts input this cycle
- out_data  out  DATA_W  output element (0 when dropped)
- out_valid  out  1  output element valid
- out_ready  in  1  downstream accepts output
- out_last  out  1  marks the final element of the vector, qualified by out_valid
- busy  out  1  high while state ≠ IDLE
- done  out  1  one-cycle pulse after the last element is handed off
- drop_count  out  $clog2(VEC_LEN+1)  number of elements dropped in the current or last vector

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=0.
  - start=1 → latch train_en and drop_thresh; clear idx and drop_count; go to RUN.
- RUN:
  - in_ready = !out_valid || out_ready. The output stage is a one-deep register.
  - An element is accepted when in_valid && in_ready. On acceptance:
    - drop = train_q && (lfsr[7:0] < thresh_q)
    - out_data ← drop ? 0 : in_data
    - out_valid ← 1
    - out_last ← (idx == VEC_LEN-1)
    - idx ← idx+1
    - LFSR advances one step
    - drop_count increments if drop
  - Handoff (out_valid && out_ready) with no new acceptance in the same cycle → out_valid ← 0.
  - Handoff and acceptance in the same cycle → the register reloads; out_valid stays 1.
  - After the element with idx = VEC_LEN-1 is accepted, in_ready is forced to 0 for the rest of RUN.
  - Handoff with out_last=1 → go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE. drop_count holds its value until the next accepted start.
- start is ignored in RUN and DONE.
- LFSR:
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1, mask 16'hB400.
  - Update: lfsr ← (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 0).
  - Advances only on accepted elements, and advances whether or not train_en is set.
  - Not reinitialised between vectors; reset is its only reinitialisation.
  - Never reaches 0.
- Inference (train_q=0): no element is dropped; drop_count stays 0.
- drop_thresh=0 never drops. drop_thresh=255 drops every element except those whose draw low byte is 8'hFF.

## Timing
- Reset values: state IDLE, in_ready 0, out_valid 0, out_last 0, out_data 0, busy 0, done 0, drop_count 0, lfsr LFSR_SEED.
- The rst assertion has priority over every other event. A rst during RUN aborts the vector without emitting done; the in-flight output is discarded (out_valid → 0 on the next edge).
- Start to RUN: 1 cycle. in_ready can first be high in the cycle after start is sampled.
- Input accept to out_valid: 1 cycle.
- Throughput is 1 element/cycle with out_ready held high. Minimum vector time is VEC_LEN+2 cycles from start to done.
- out_data, out_last and out_valid stay stable while out_valid && !out_ready.
- busy rises the cycle after an accepted start and falls the cycle after the done pulse.

## Test plan
- Pass-through check:
  - Stimulus: VEC_LEN=16, train_en=1, drop_thresh=0, inputs 1..16, out_ready held high.
  - Required: outputs 1..16 in order; out_last only on 16; drop_count=0; done 18 cycles after start.
- Inference mode:
  - Stimulus: train_en=0, drop_thresh=255, inputs 8'hFF.
  - Required: all 16 outputs are 8'hFF; drop_count=0; the LFSR still advances 16 steps, checked against the model on the next training vector.
- Mask model compare:
  - Stimulus: train_en=1, drop_thresh=128, 64 back-to-back vectors.
  - Required: every output and every drop_count match a scoreboard LFSR model seeded with 16'hACE1; total drops fall within 40–60% of 1024 elements.
- Backpressure:
  - Stimulus: out_ready randomly low 50% of the time.
  - Required: no lost or duplicated elements; out_* stable while stalled; in_ready=0 whenever out_valid && !out_ready.
- Reset mid-run:
  - Stimulus: assert rst after 5 accepted elements.
  - Required: next cycle shows state IDLE with all outputs at reset values; no done pulse; LFSR back to 16'hACE1, so a fresh vector reproduces the first vector's mask.
- Start during RUN:
  - Stimulus: pulse start with drop_thresh=255 mid-vector.
  - Required: ignored; the original latched threshold stays in use; done is pulsed exactly once.
